// File: rtl/regfile_wb_pkg.sv
// ============================================================================
//  Module      : regfile_wb_pkg
//  Description : Shared constants, write-back request type and mask helpers
//                for the register-file write-back sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

  localparam int NREG = 16;
  localparam int AW   = $clog2(NREG);
  localparam int DW   = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          rs1_en;
    logic [AW-1:0] rs1;
    logic [DW-1:0] rs1_data;
  } wb_req_t;

  function automatic logic [NREG-1:0] onehot_mask(input logic [AW-1:0] addr);
    logic [NREG-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

  // Registers a request will touch; R0 is never reported as pending.
  function automatic logic [NREG-1:0] req_mask(input logic [AW-1:0] rd,
                                               input logic          rs1_en,
                                               input logic [AW-1:0] rs1);
    logic [NREG-1:0] m;
    m = onehot_mask(rd);
    if (rs1_en) m = m | onehot_mask(rs1);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_sequencer_if.sv
// ============================================================================
//  Module      : regfile_wb_sequencer_if
//  Description : Request handshake and register-file write bus of the
//                write-back sequencer. Forwarding signals exist only when
//                WB_FWD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_sequencer_if import regfile_wb_pkg::*; ();

  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_rd;
  logic [DW-1:0]   req_data;
  logic            req_rs1_en;
  logic [AW-1:0]   req_rs1;
  logic [DW-1:0]   req_rs1_data;
  logic            flush;

  logic [AW-1:0]   RW;
  logic [DW-1:0]   Bus_W;
  logic            RegRw;
  logic            Rs1Rw;
  logic [DW-1:0]   Bus_W1;
  logic [AW-1:0]   wb_rs1_addr;
  logic            ra_sel;
  logic [NREG-1:0] pending;

`ifdef WB_FWD_EN
  logic [AW-1:0]   fwd_addr_a;
  logic [AW-1:0]   fwd_addr_b;
  logic            fwd_hit_a;
  logic            fwd_hit_b;
  logic [DW-1:0]   fwd_data_a;
  logic [DW-1:0]   fwd_data_b;
`endif

  modport master (
    output req_valid, req_rd, req_data, req_rs1_en, req_rs1, req_rs1_data, flush,
`ifdef WB_FWD_EN
    output fwd_addr_a, fwd_addr_b,
    input  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b,
`endif
    input  req_ready, RW, Bus_W, RegRw, Rs1Rw, Bus_W1, wb_rs1_addr, ra_sel, pending
  );

  modport slave (
    input  req_valid, req_rd, req_data, req_rs1_en, req_rs1, req_rs1_data, flush,
`ifdef WB_FWD_EN
    input  fwd_addr_a, fwd_addr_b,
    output fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b,
`endif
    output req_ready, RW, Bus_W, RegRw, Rs1Rw, Bus_W1, wb_rs1_addr, ra_sel, pending
  );

endinterface

`default_nettype wire

// File: rtl/wb_req_fifo.sv
// ============================================================================
//  Module      : wb_req_fifo
//  Description : DEPTH-entry circular request buffer with push, pop, flush,
//                full/empty flags and per-entry valid bits and register masks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_req_fifo import regfile_wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            push,
  input  wire logic            pop,
  input  wire logic            flush,
  input  wire wb_req_t         din,
  output wb_req_t              dout,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH-1:0]     entry_valid,
  output logic [NREG-1:0]      entry_mask [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push_ok;
  logic           pop_ok;

  // Flush wins over both ports so a same-cycle request is dropped.
  assign push_ok = push && !full  && !flush;
  assign pop_ok  = pop  && !empty && !flush;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage array; contents are qualified by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset         = PW'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, offset} < count);
    assign entry_mask[i]  = req_mask(mem[i].rd, mem[i].rs1_en, mem[i].rs1);
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_sequencer.sv
// ============================================================================
//  Module      : regfile_wb_sequencer
//  Description : Write-back end of the register-file interface. Queues
//                write-back requests, issues one write slot per cycle with
//                R0 and rd/rs1 collision suppression, and exports a pending
//                mask. Define WB_FWD_EN to add issue-slot forwarding ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_sequencer import regfile_wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  regfile_wb_sequencer_if.slave bus
);

  wb_req_t          req_in;
  wb_req_t          head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue;
  logic             head_rs1_wr;
  logic [DEPTH-1:0] entry_valid;
  logic [NREG-1:0]  entry_mask [DEPTH];

  logic             slot_valid;
  logic [NREG-1:0]  slot_mask;
  logic [AW-1:0]    slot_rw;
  logic [DW-1:0]    slot_bus_w;
  logic             slot_regrw;
  logic             slot_rs1rw;
  logic [DW-1:0]    slot_bus_w1;
  logic [AW-1:0]    slot_rs1_addr;
  logic [NREG-1:0]  pend;

  assign req_in = '{rd: bus.req_rd, data: bus.req_data, rs1_en: bus.req_rs1_en,
                    rs1: bus.req_rs1, rs1_data: bus.req_rs1_data};

  wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (bus.req_valid),
    .pop         (issue),
    .flush       (bus.flush),
    .din         (req_in),
    .dout        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_mask  (entry_mask)
  );

  // Flushed entries must never reach the slot, so flush blocks the pop.
  assign issue       = !fifo_empty && !bus.flush;
  // rs1 write is dropped for R0 and when it targets the same register as rd.
  assign head_rs1_wr = head.rs1_en && (head.rs1 != '0) && (head.rs1 != head.rd);

  // Issue slot: load the FIFO head, or go idle keeping RW/Bus_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid    <= 1'b0;
      slot_mask     <= '0;
      slot_rw       <= '0;
      slot_bus_w    <= '0;
      slot_regrw    <= 1'b0;
      slot_rs1rw    <= 1'b0;
      slot_bus_w1   <= '0;
      slot_rs1_addr <= '0;
    end else if (issue) begin
      slot_valid    <= 1'b1;
      slot_mask     <= req_mask(head.rd, head.rs1_en, head.rs1);
      slot_rw       <= head.rd;
      slot_bus_w    <= head.data;
      slot_regrw    <= (head.rd != '0);
      slot_rs1rw    <= head_rs1_wr;
      slot_bus_w1   <= head_rs1_wr ? head.rs1_data : '0;
      slot_rs1_addr <= head_rs1_wr ? head.rs1 : '0;
    end else begin
      slot_valid    <= 1'b0;
      slot_mask     <= '0;
      slot_regrw    <= 1'b0;
      slot_rs1rw    <= 1'b0;
      slot_bus_w1   <= '0;
      slot_rs1_addr <= '0;
    end
  end

  // Pending mask: OR of the issue slot and every valid queued entry.
  always_comb begin
    pend = slot_valid ? slot_mask : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pend = pend | entry_mask[i];
    end
  end

  assign bus.req_ready   = !fifo_full;
  assign bus.RW          = slot_rw;
  assign bus.Bus_W       = slot_bus_w;
  assign bus.RegRw       = slot_regrw;
  assign bus.Rs1Rw       = slot_rs1rw;
  assign bus.Bus_W1      = slot_bus_w1;
  assign bus.wb_rs1_addr = slot_rs1_addr;
  assign bus.ra_sel      = slot_rs1rw;
  assign bus.pending     = pend;

`ifdef WB_FWD_EN
  // Forward the value being written this cycle; rd match beats rs1 match.
  always_comb begin
    bus.fwd_hit_a  = 1'b0;
    bus.fwd_data_a = '0;
    bus.fwd_hit_b  = 1'b0;
    bus.fwd_data_b = '0;
    if (bus.fwd_addr_a != '0) begin
      if (slot_regrw && (slot_rw == bus.fwd_addr_a)) begin
        bus.fwd_hit_a  = 1'b1;
        bus.fwd_data_a = slot_bus_w;
      end else if (slot_rs1rw && (slot_rs1_addr == bus.fwd_addr_a)) begin
        bus.fwd_hit_a  = 1'b1;
        bus.fwd_data_a = slot_bus_w1;
      end
    end
    if (bus.fwd_addr_b != '0) begin
      if (slot_regrw && (slot_rw == bus.fwd_addr_b)) begin
        bus.fwd_hit_b  = 1'b1;
        bus.fwd_data_b = slot_bus_w;
      end else if (slot_rs1rw && (slot_rs1_addr == bus.fwd_addr_b)) begin
        bus.fwd_hit_b  = 1'b1;
        bus.fwd_data_b = slot_bus_w1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
